receiver: RTL and testbench

Serial-to-matrix UART receiver, the downstream counterpart of the team's matrix transmitter. It samples the `rx` line at `DIV` clocks per bit and checks start, stop and optional parity bits. Each accepted word is stored into a 2x4 matrix of `W`-bit cells at an auto-incrementing write pointer. The host reads cells through a combinational row/column port and gets per-word valid and error strobes.

---
 rtl/receiver.sv | 180 ++++++++++++++++++
 tb/tb_receiver.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/receiver.sv
// Serial-to-matrix UART receiver: start/data/parity/stop framing, words stored into a 2x4 matrix.
// Optional RX_SYNC_EN adds a two-flop synchronizer (reset value 1) in front of the FSM.
module receiver #(
  parameter int W   = 8,
  parameter int DIV = 3,
  parameter int PAR = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         row,
  input  logic [1:0]   col,
  input  logic [1:0]   cmd,
  output logic [W-1:0] r_cell,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         ferr,
  output logic         perr,
  output logic         busy,
  output logic         wr_row,
  output logic [1:0]   wr_col
);

  localparam int CELLS = 8;
  localparam int H     = (DIV - 1) / 2;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(H);
  localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d, cnt_nxt;
  logic [BW-1:0]  bitn_q, bitn_d;
  logic [W-1:0]   sh_q, sh_d;
  logic           werr_q, werr_d;
  logic [W-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           perr_q, perr_d;
  logic [2:0]     ptr_q, ptr_d;
  logic [W-1:0]   mat_q [CELLS];
  logic [W-1:0]   mat_d [CELLS];
  logic           rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  assign cnt_nxt = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    sh_d    = sh_q;
    werr_d  = werr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = perr_q;
    ptr_d   = ptr_q;
    mat_d   = mat_q;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          werr_d = 1'b0;
          bitn_d = '0;
          if (H == 0) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            state_d = START;
            cnt_d   = CW'(1);
          end
        end
      end
      START: begin
        if (cnt_q == CNT_H) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        cnt_d = cnt_nxt;
        if (cnt_q == CNT_LAST) begin
          sh_d = {rx_s, sh_q[W-1:1]};
          if (bitn_q == BIT_LAST) state_d = (PAR != 0) ? PARITY : STOP;
          else                    bitn_d  = bitn_q + BW'(1);
        end
      end
      PARITY: begin
        cnt_d = cnt_nxt;
        if (cnt_q == CNT_LAST) begin
          // odd parity expects the inverse of the data XOR
          if (rx_s != ((^sh_q) ^ (PAR == 2))) werr_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_nxt;
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          if (rx_s) begin
            mat_d[ptr_q] = sh_q;
            data_d       = sh_q;
            valid_d      = 1'b1;
            ptr_d        = ptr_q + 3'd1;
            if (werr_q) perr_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      case (cmd)
        2'd1: ptr_d = {row, col};
        2'd2: begin
          for (int unsigned i = 0; i < CELLS; i++) mat_d[i] = '0;
          ptr_d  = '0;
          perr_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bitn_q  <= '0;
      sh_q    <= '0;
      werr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      ptr_q   <= '0;
      for (int unsigned i = 0; i < CELLS; i++) mat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      sh_q    <= sh_d;
      werr_q  <= werr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ptr_q   <= ptr_d;
      mat_q   <= mat_d;
    end
  end

  assign r_cell = mat_q[{row, col}];
  assign data   = data_q;
  assign valid  = valid_q;
  assign ferr   = ferr_q;
  assign perr   = perr_q;
  assign busy   = (state_q != IDLE);
  assign wr_row = ptr_q[2];
  assign wr_col = ptr_q[1:0];

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: two instances (no parity, even parity) against a matrix/pointer model.
module tb_receiver;
  localparam int DIV = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic       row = 1'b0;
  logic [1:0] col = '0;
  logic [1:0] cmd = '0;
  logic [7:0] rc0, rc1, d0, d1;
  logic       v0, v1, f0, f1, p0, p1, b0, b1, wr0, wr1;
  logic [1:0] wc0, wc1;

  receiver #(.W(8), .DIV(DIV), .PAR(0)) u_dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .row(row), .col(col), .cmd(cmd),
    .r_cell(rc0), .data(d0), .valid(v0), .ferr(f0), .perr(p0), .busy(b0),
    .wr_row(wr0), .wr_col(wc0));

  receiver #(.W(8), .DIV(DIV), .PAR(1)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .row(row), .col(col), .cmd(cmd),
    .r_cell(rc1), .data(d1), .valid(v1), .ferr(f1), .perr(p1), .busy(b1),
    .wr_row(wr1), .wr_col(wc1));

  always #5 clk = ~clk;

  typedef struct packed {bit fe; logic [7:0] d; bit pe;} ev_t;
  ev_t q0[$], q1[$];

  logic [7:0] m [2][8];
  int         mptr [2];
  bit         mperr [2];
  int         checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 8; i++) m[u][i] = '0;
      mptr[u]  = 0;
      mperr[u] = 1'b0;
    end
  endtask

  // Expected outcome of one frame, derived from the framing rules.
  task automatic expect_frame(input int u, input logic [7:0] d, input bit pbit, input bit stop);
    ev_t e;
    bit pbad;
    pbad = (u == 1) && (pbit != (^d));
    if (stop) begin
      m[u][mptr[u]] = d;
      mptr[u] = (mptr[u] + 1) % 8;
      if (pbad) mperr[u] = 1'b1;
      e = '{fe: 1'b0, d: d, pe: mperr[u]};
    end else begin
      e = '{fe: 1'b1, d: 8'h00, pe: mperr[u]};
    end
    if (u == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic put(input int u, input bit b);
    if (u == 0) rx0 = b; else rx1 = b;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send(input int u, input logic [7:0] d, input bit pbit, input bit stop);
    expect_frame(u, d, pbit, stop);
    put(u, 1'b0);
    for (int i = 0; i < 8; i++) put(u, d[i]);
    if (u == 1) put(u, pbit);
    put(u, stop);
    if (u == 0) rx0 = 1'b1; else rx1 = 1'b1;
    if (!stop) repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic r, input logic [1:0] cl);
    repeat (4) @(negedge clk);
    cmd = c; row = r; col = cl;
    @(negedge clk);
    cmd = 2'd0;
    for (int u = 0; u < 2; u++) begin
      if (c == 2'd1) mptr[u] = {29'd0, r, cl};
      if (c == 2'd2) begin
        for (int i = 0; i < 8; i++) m[u][i] = '0;
        mptr[u]  = 0;
        mperr[u] = 1'b0;
      end
    end
  endtask

  task automatic chk_state(input int u, input string tag);
    for (int i = 0; i < 8; i++) begin
      row = i[2];
      col = i[1:0];
      #1;
      chk($sformatf("%s_u%0d_cell%0d", tag, u, i), (u == 0) ? rc0 : rc1, m[u][i]);
    end
    chk($sformatf("%s_u%0d_ptr", tag, u), (u == 0) ? {wr0, wc0} : {wr1, wc1}, mptr[u]);
    chk($sformatf("%s_u%0d_perr", tag, u), (u == 0) ? p0 : p1, mperr[u]);
  endtask

  task automatic mon(input int u, input logic v, input logic f, input logic [7:0] d, input logic p);
    ev_t e;
    if (v || f) begin
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
        chk($sformatf("u%0d_unexpected_strobe", u), {v, f}, 2'b00);
      end else begin
        e = (u == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("u%0d_strobe_kind", u), {v, f}, e.fe ? 2'b01 : 2'b10);
        if (!e.fe) chk($sformatf("u%0d_data", u), d, e.d);
        chk($sformatf("u%0d_perr_at_strobe", u), p, e.pe);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, v0, f0, d0, p0);
      mon(1, v1, f1, d1, p1);
    end
  end

  initial begin
    logic [7:0] rd;
    bit         pb, st;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data", d0, 8'h00);
    chk("rst_strobes", {v0, f0, p0, b0, v1, f1, p1, b1}, 8'h00);
    chk_state(0, "rst");

    send(0, 8'hA5, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("a5_data", d0, 8'hA5);
    chk_state(0, "a5");

    do_cmd(2'd2, 1'b0, 2'd0);
    for (int i = 1; i <= 9; i++) send(0, 8'(i), 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk_state(0, "nine");

    send(1, 8'h03, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("par_perr_set", p1, 1'b1);
    chk_state(1, "par");
    do_cmd(2'd2, 1'b0, 2'd0);
    chk("par_perr_clr", p1, 1'b0);
    chk_state(1, "parclr");

    send(0, 8'h55, 1'b0, 1'b0);
    chk_state(0, "ferr");

    rx0 = 1'b0;
    @(negedge clk);
    rx0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("false_start_busy", b0, 1'b0);
    do_cmd(2'd1, 1'b1, 2'd2);
    send(0, 8'h7E, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk_state(0, "setptr");

    // abort partway through data bit 4
    put(0, 1'b0);
    for (int i = 0; i < 4; i++) put(0, rd[0] ^ 1'b1);
    rx0 = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_outs", {d0, v0, f0, p0, b0, wr0, wc0}, 15'd0);
    chk("midrst_cell12", rc0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(0, 8'h3C, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk_state(0, "postrst");

    for (int n = 0; n < 24; n++) begin
      rd = 8'($urandom);
      st = ($urandom_range(0, 5) != 0);
      send(0, rd, 1'b0, st);
      rd = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^rd) : ^rd;
      st = ($urandom_range(0, 5) != 0);
      send(1, rd, pb, st);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (n == 11) do_cmd(2'd2, 1'b0, 2'd0);
    end
    repeat (4) @(negedge clk);
    chk_state(0, "rand");
    chk_state(1, "rand");
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
